// File: rtl/spi_axis_pkg.sv
// Shared constants and FIFO entry layout for the SPI <-> AXI-Stream bridge.
package spi_axis_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/spi_axis_fifo.sv
// Synchronous FIFO of {last, data} entries with an AXI-Stream read side.
module spi_axis_fifo
  import spi_axis_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] push_data_i,
  input  logic              push_last_i,
  output logic              full_o,
  output logic [BYTE_W-1:0] m_axis_tdata_o,
  output logic              m_axis_tvalid_o,
  output logic              m_axis_tlast_o,
  input  logic              m_axis_tready_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fifo_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 push_ok;
  logic                 pop;
  fifo_entry_t          head;

  assign full_o          = (count_q == CNT_W'(DEPTH));
  assign m_axis_tvalid_o = (count_q != '0);
  assign push_ok         = push_i && !full_o;
  assign pop             = m_axis_tvalid_o && m_axis_tready_i;

  // Empty FIFO presents zeros so the output is defined straight out of reset.
  assign head           = m_axis_tvalid_o ? mem_q[rd_ptr_q] : '0;
  assign m_axis_tdata_o = head.data;
  assign m_axis_tlast_o = head.last;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= '{last: push_last_i, data: push_data_i};
    end
  end

endmodule

// File: rtl/spi_axis_bridge.sv
// SPI mode-0 slave bridging MOSI bytes to M_AXIS (with per-frame TLAST)
// and S_AXIS bytes to MISO, all in the clk domain.
module spi_axis_bridge
  import spi_axis_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH = 16,
  parameter logic [BYTE_W-1:0] IDLE_MISO  = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  input  logic [BYTE_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [BYTE_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  logic [BYTE_W-1:0]    rx_sr_q, rx_sr_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    pend_q, pend_d;
  logic                 pend_valid_q, pend_valid_d;
  logic                 frame_q, frame_d;
  logic [BYTE_W-1:0]    tx_hold_q, tx_hold_d;
  logic                 tx_hold_valid_q, tx_hold_valid_d;
  logic [BYTE_W-1:0]    tx_sr_q, tx_sr_d;
  logic                 miso_q, miso_d;

  logic              sck_rise, sck_fall, cs_rise, cs_fall;
  logic              rx_en, byte_done, s_hs;
  logic [BYTE_W-1:0] rx_byte;
  logic              push, push_last;
  logic              fifo_full;

  assign sck_rise  = sck_sync_q & ~sck_prev_q;
  assign sck_fall  = ~sck_sync_q & sck_prev_q;
  assign cs_fall   = ~cs_sync_q & cs_prev_q;
  assign cs_rise   = cs_sync_q & ~cs_prev_q;
  // A frame only counts once its CS fall was seen, so a reset mid-frame waits for the next one.
  assign rx_en     = ~cs_sync_q & frame_q;
  assign rx_byte   = {rx_sr_q[BYTE_W-2:0], mosi_sync_q};
  assign byte_done = sck_rise && rx_en && (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1));
  assign s_hs      = s_axis_tvalid & ~tx_hold_valid_q;

  assign s_axis_tready = ~tx_hold_valid_q;
  assign spi_miso      = miso_q;

  // Receive path with one-byte TLAST holdback.
  always_comb begin
    rx_sr_d      = rx_sr_q;
    bit_cnt_d    = bit_cnt_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    frame_d      = frame_q;
    push         = 1'b0;
    push_last    = 1'b0;
    if (cs_fall) begin
      bit_cnt_d = '0;
      frame_d   = 1'b1;
    end else if (cs_rise) begin
      bit_cnt_d    = '0;
      frame_d      = 1'b0;
      push         = pend_valid_q;
      push_last    = 1'b1;
      pend_valid_d = 1'b0;
    end else if (sck_rise && rx_en) begin
      rx_sr_d   = rx_byte;
      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      if (byte_done) begin
        push         = pend_valid_q;
        pend_d       = rx_byte;
        pend_valid_d = 1'b1;
      end
    end
  end

  // Transmit path; the fall right after a byte boundary must keep the freshly loaded MSB.
  always_comb begin
    tx_hold_d       = tx_hold_q;
    tx_hold_valid_d = tx_hold_valid_q;
    tx_sr_d         = tx_sr_q;
    if (s_hs) begin
      tx_hold_d       = s_axis_tdata;
      tx_hold_valid_d = 1'b1;
    end
    if (cs_fall || byte_done) begin
      if (tx_hold_valid_q) begin
        tx_sr_d         = tx_hold_q;
        tx_hold_valid_d = 1'b0;
      end else begin
        tx_sr_d = IDLE_MISO;
      end
    end else if (sck_fall && rx_en && (bit_cnt_q != '0)) begin
      tx_sr_d = {tx_sr_q[BYTE_W-2:0], 1'b0};
    end
    miso_d = tx_sr_d[BYTE_W-1] & ~cs_meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_meta_q      <= 1'b0;
      sck_sync_q      <= 1'b0;
      sck_prev_q      <= 1'b0;
      cs_meta_q       <= 1'b0;
      cs_sync_q       <= 1'b0;
      cs_prev_q       <= 1'b0;
      mosi_meta_q     <= 1'b0;
      mosi_sync_q     <= 1'b0;
      rx_sr_q         <= '0;
      bit_cnt_q       <= '0;
      pend_q          <= '0;
      pend_valid_q    <= 1'b0;
      frame_q         <= 1'b0;
      tx_hold_q       <= '0;
      tx_hold_valid_q <= 1'b0;
      tx_sr_q         <= '0;
      miso_q          <= 1'b0;
    end else begin
      sck_meta_q      <= spi_clk;
      sck_sync_q      <= sck_meta_q;
      sck_prev_q      <= sck_sync_q;
      cs_meta_q       <= spi_cs_n;
      cs_sync_q       <= cs_meta_q;
      cs_prev_q       <= cs_sync_q;
      mosi_meta_q     <= spi_mosi;
      mosi_sync_q     <= mosi_meta_q;
      rx_sr_q         <= rx_sr_d;
      bit_cnt_q       <= bit_cnt_d;
      pend_q          <= pend_d;
      pend_valid_q    <= pend_valid_d;
      frame_q         <= frame_d;
      tx_hold_q       <= tx_hold_d;
      tx_hold_valid_q <= tx_hold_valid_d;
      tx_sr_q         <= tx_sr_d;
      miso_q          <= miso_d;
    end
  end

  spi_axis_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk             (clk),
    .rst             (rst),
    .push_i          (push),
    .push_data_i     (pend_q),
    .push_last_i     (push_last),
    .full_o          (fifo_full),
    .m_axis_tdata_o  (m_axis_tdata),
    .m_axis_tvalid_o (m_axis_tvalid),
    .m_axis_tlast_o  (m_axis_tlast),
    .m_axis_tready_i (m_axis_tready)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, s_axis_tlast, fifo_full};

endmodule

// File: tb/tb_spi_axis_bridge.sv
// Scoreboard bench: drives an SPI master and S_AXIS, checks M_AXIS beats and MISO bytes.
module tb_spi_axis_bridge;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int          HALF       = 53;

  logic       clk, rst;
  logic       spi_clk, spi_mosi, spi_cs_n, spi_miso;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tready, m_axis_tlast;

  int         n_checks, n_errors, s_sent;
  logic [8:0] exp_q[$];
  logic [7:0] tx_bytes[$];
  logic [7:0] rx_bytes[$];

  spi_axis_bridge #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .IDLE_MISO  (8'h00)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .spi_clk       (spi_clk),
    .spi_mosi      (spi_mosi),
    .spi_cs_n      (spi_cs_n),
    .spi_miso      (spi_miso),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: each accepted beat must match the oldest expected {last, data}.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        check("beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      #HALF;
      spi_clk = 1'b1;
      rx[i]   = spi_miso;
      #HALF;
      spi_clk = 1'b0;
    end
  endtask

  // Sends tx_bytes as one CS frame; keep_all=0 models FIFO overflow with tready held low.
  task automatic run_frame(input bit keep_all);
    logic [7:0] rx;
    int n;
    n = tx_bytes.size();
    for (int i = 0; i < n; i++) begin
      if (keep_all) exp_q.push_back({(i == n - 1), tx_bytes[i]});
      else if (i < FIFO_DEPTH) exp_q.push_back({1'b0, tx_bytes[i]});
    end
    spi_cs_n = 1'b0;
    #HALF;
    for (int i = 0; i < n; i++) begin
      spi_byte(tx_bytes[i], rx);
      rx_bytes.push_back(rx);
    end
    #HALF;
    spi_cs_n = 1'b1;
    #(4 * HALF);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic s_send(input logic [7:0] b);
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_sent++;
        return;
      end
    end
    s_axis_tvalid = 1'b0;
    check("s_axis_accept", 32'(s_axis_tready), 32'd1);
  endtask

  task automatic set_tready(input logic v);
    @(posedge clk);
    #1;
    m_axis_tready = v;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; s_sent = 0;
    rst = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
    s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata",  32'(m_axis_tdata),  32'd0);
    check("rst_tlast",  32'(m_axis_tlast),  32'd0);
    check("rst_sready", 32'(s_axis_tready), 32'd1);
    check("rst_miso",   32'(spi_miso),      32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Single byte frame.
    tx_bytes = '{8'h01};
    run_frame(1'b1);
    wait_drain();
    check("idle_miso", 32'(rx_bytes[0]), 32'h00);
    repeat (20) @(negedge clk);
    check("single_done", 32'(m_axis_tvalid), 32'd0);

    // Six-byte frame, TLAST only on the final byte.
    tx_bytes = '{8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h01};
    run_frame(1'b1);
    wait_drain();

    // MISO from S_AXIS: A5, 3C, then idle.
    fork
      begin s_send(8'hA5); s_send(8'h3C); end
    join_none
    repeat (20) @(negedge clk);
    check("hold_full", 32'(s_axis_tready), 32'd0);
    rx_bytes.delete();
    tx_bytes = '{8'h11, 8'h22, 8'h33};
    run_frame(1'b1);
    check("miso_b0", 32'(rx_bytes[0]), 32'hA5);
    check("miso_b1", 32'(rx_bytes[1]), 32'h3C);
    check("miso_b2", 32'(rx_bytes[2]), 32'h00);
    check("sready_back", 32'(s_axis_tready), 32'd1);
    check("s_sent", 32'(s_sent), 32'd2);
    wait_drain();

    // Back-to-back frames.
    tx_bytes = '{8'hAA, 8'hBB, 8'hCC};
    run_frame(1'b1);
    tx_bytes = '{8'hDD};
    run_frame(1'b1);
    wait_drain();

    // Backpressure: the held beat must stay stable.
    set_tready(1'b0);
    tx_bytes = '{8'hDD};
    run_frame(1'b1);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("hold_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'h1DD);
    end
    set_tready(1'b1);
    repeat (4) @(negedge clk);
    check("hold_released", 32'(m_axis_tvalid), 32'd0);
    check("hold_consumed", 32'(exp_q.size()), 32'd0);

    // Partial byte is discarded, and the next frame starts cleanly.
    spi_cs_n = 1'b0;
    #HALF;
    for (int i = 0; i < 5; i++) begin
      spi_mosi = 1'b1;
      #HALF; spi_clk = 1'b1;
      #HALF; spi_clk = 1'b0;
    end
    #HALF;
    spi_cs_n = 1'b1;
    #(4 * HALF);
    repeat (20) @(negedge clk);
    check("partial_none", 32'(m_axis_tvalid), 32'd0);
    tx_bytes = '{8'h5A};
    run_frame(1'b1);
    wait_drain();

    // Overflow: FIFO_DEPTH+2 bytes with tready low; only the first FIFO_DEPTH survive.
    set_tready(1'b0);
    tx_bytes.delete();
    for (int i = 0; i < FIFO_DEPTH + 2; i++) tx_bytes.push_back(8'(8'h40 + i));
    run_frame(1'b0);
    repeat (20) @(negedge clk);
    check("ovf_tvalid", 32'(m_axis_tvalid), 32'd1);
    set_tready(1'b1);
    wait_drain();
    repeat (10) @(negedge clk);
    check("ovf_empty", 32'(m_axis_tvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
